q_pulse_serializer: RTL and testbench
=====================================

Name: q_pulse_serializer

Overview:
- Transmit-side counterpart of the charge-measurement receiver.
- Takes a charge value and emits a framed train of fixed-width pulses on `q_serialized`. Each pulse represents Q_PER_PULSE charge units; the count is rounded to nearest.
- One frame: a `start_out` strobe, a lead gap, the pulse train, then a quiet tail long enough for the receiver's watchdog to close its window.
- Used as the charge source in closed-loop benches and in the resonant-system emulation path.

Parameters:
- BUS_WIDTH, 10, width of charge value and pulse-count buses.
- Q_PER_PULSE, 30, charge units per pulse; >=1.
- PULSE_DURATION, 3, cycles `q_serialized` is high per pulse; 1..255.
- GAP_DURATION, 3, low cycles after each pulse; 1..255.
- LEAD_CYCLES, 2, low cycles between `start_out` and first pulse; 1..255.
- TAIL_CYCLES, 8, low cycles after last gap before `done`; 1..255; must exceed the receiver watchdog timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- valid  input  1  request to send `q_in`; sampled only in IDLE.
- q_in  input  BUS_WIDTH  charge value to serialize.
- abort  input  1  terminate the current pulse train early; ignored in IDLE.
- start_out  output  1  one-cycle frame-start strobe, drives receiver `start`.
- q_serialized  output  1  serialized pulse stream.
- busy  output  1  frame in progress.
- done  output  1  one-cycle frame-complete strobe.
- pulse_count  output  BUS_WIDTH  pulses emitted in the current or last frame.
- q_sent  output  BUS_WIDTH  pulse_count*Q_PER_PULSE, saturated at 2**BUS_WIDTH-1.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and the remainder register are 0.
- All outputs are registered Moore outputs of the state.
- Remainder register `rem` is BUS_WIDTH+1 bits. HALF = (Q_PER_PULSE+1)/2, using integer division.
- A pulse is emitted while rem >= HALF. This gives pulses = round-half-up(q_in/Q_PER_PULSE), with no divider.
- States and transitions:
  - IDLE: busy=0. If valid=1, latch rem<=q_in, clear pulse_count and q_sent, go to START.
  - START: start_out=1 and busy=1 for exactly 1 cycle, then go to LEAD.
  - LEAD: low for LEAD_CYCLES cycles. Then go to HIGH if rem>=HALF, else TAIL.
  - HIGH: q_serialized=1 for PULSE_DURATION cycles. On the last cycle: rem<=max(rem-Q_PER_PULSE,0), pulse_count+=1, q_sent+=Q_PER_PULSE saturating. Then go to LOW.
  - LOW: low for GAP_DURATION cycles. Then go to HIGH if rem>=HALF, else TAIL.
  - TAIL: low for TAIL_CYCLES cycles, then go to DONE.
  - DONE: done=1 for 1 cycle, busy=1, then go to IDLE. `pulse_count` and `q_sent` hold until the next accepted valid.
- Latency: valid sampled at cycle 0 gives start_out at cycle 1 and the first high cycle at 2+LEAD_CYCLES.
- Frame length from START through DONE: 2 + LEAD_CYCLES + N*(PULSE_DURATION+GAP_DURATION) + TAIL_CYCLES.
- q_in=0, or q_in<HALF: zero pulses. The frame is still sent (START, LEAD, TAIL, DONE) so the receiver reports 0.
- valid while busy=1 is ignored; there is no queueing. valid in the DONE cycle is ignored; valid in the following IDLE cycle is accepted.
- abort in START or LEAD: go to TAIL next cycle.
- abort in HIGH: q_serialized drops next cycle, go to TAIL. The truncated pulse is not counted.
- abort in LOW: go to TAIL.
- abort in TAIL or DONE: no effect. abort in IDLE: ignored, and valid in the same cycle is still accepted.
- rst mid-frame: next cycle is IDLE with all outputs 0. No done is issued.
- Saturation: q_sent never wraps. pulse_count cannot overflow, since N <= q_in when Q_PER_PULSE>=1.

Test Plan:
- Defaults, q_in=100 at cycle 0 -> start_out at cycle 1; highs at cycles 4-6, 10-12, 16-18; done at cycle 30; pulse_count=3, q_sent=90.
- q_in=105 -> 4 pulses (rem reaches 15>=HALF=15), q_sent=120. q_in=14 -> 0 pulses, done at cycle 12, q_sent=0.
- Q_PER_PULSE=600, q_in=1023 -> 2 pulses, q_sent saturates at 1023.
- q_in=300, abort during the 2nd HIGH cycle of pulse 2 -> q_serialized low next cycle, 8 TAIL cycles, then done; pulse_count=1.
- valid re-asserted every cycle during a frame -> exactly one frame. valid the cycle after done -> new start_out one cycle later.
- rst asserted in LOW of pulse 1 -> next cycle all outputs 0 and busy=0, no done. A subsequent q_in=60 frame gives 2 pulses.

Source files
------------

// File: rtl/q_pulse_serializer_if.sv
// Handshake and result bundle between a charge source controller and q_pulse_serializer.
interface q_pulse_serializer_if #(
  parameter int unsigned BUS_WIDTH = 10
);
  logic                 valid;
  logic [BUS_WIDTH-1:0] q_in;
  logic                 abort;
  logic                 start_out;
  logic                 q_serialized;
  logic                 busy;
  logic                 done;
  logic [BUS_WIDTH-1:0] pulse_count;
  logic [BUS_WIDTH-1:0] q_sent;

  modport master (
    output valid, q_in, abort,
    input  start_out, q_serialized, busy, done, pulse_count, q_sent
  );

  modport slave (
    input  valid, q_in, abort,
    output start_out, q_serialized, busy, done, pulse_count, q_sent
  );
endinterface

// File: rtl/q_pulse_serializer.sv
// Serializes a charge value into a framed train of fixed-width pulses, one pulse per
// Q_PER_PULSE charge units, rounded to nearest via a remainder register.
module q_pulse_serializer #(
  parameter int unsigned BUS_WIDTH      = 10,
  parameter int unsigned Q_PER_PULSE    = 30,
  parameter int unsigned PULSE_DURATION = 3,
  parameter int unsigned GAP_DURATION   = 3,
  parameter int unsigned LEAD_CYCLES    = 2,
  parameter int unsigned TAIL_CYCLES    = 8
) (
  input logic                  clk,
  input logic                  rst,
  q_pulse_serializer_if.slave  bus
);

  localparam int unsigned RemW = BUS_WIDTH + 1;
  localparam logic [31:0] Half = 32'((Q_PER_PULSE + 1) / 2);
  localparam logic [31:0] QMax = 32'((2 ** BUS_WIDTH) - 1);
  localparam logic [7:0]  LeadLast  = 8'(LEAD_CYCLES - 1);
  localparam logic [7:0]  PulseLast = 8'(PULSE_DURATION - 1);
  localparam logic [7:0]  GapLast   = 8'(GAP_DURATION - 1);
  localparam logic [7:0]  TailLast  = 8'(TAIL_CYCLES - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StLead  = 3'd2;
  localparam logic [2:0] StHigh  = 3'd3;
  localparam logic [2:0] StLow   = 3'd4;
  localparam logic [2:0] StTail  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [RemW-1:0]      rem_q, rem_d;
  logic [BUS_WIDTH-1:0] pulse_count_q, pulse_count_d;
  logic [BUS_WIDTH-1:0] q_sent_q, q_sent_d;
  logic                 start_q, ser_q, busy_q, done_q;
  logic                 pulse_due;
  logic [31:0]          q_sum;

  // Rounding comes from emitting while the leftover is at least half a quantum.
  assign pulse_due = 32'(rem_q) >= Half;
  assign q_sum     = 32'(q_sent_q) + Q_PER_PULSE;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 8'd1;
    rem_d         = rem_q;
    pulse_count_d = pulse_count_q;
    q_sent_d      = q_sent_q;
    case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (bus.valid) begin
          rem_d         = RemW'(bus.q_in);
          pulse_count_d = '0;
          q_sent_d      = '0;
          state_d       = StStart;
        end
      end
      StStart: begin
        cnt_d   = 8'd0;
        state_d = bus.abort ? StTail : StLead;
      end
      StLead: begin
        if (bus.abort) begin
          cnt_d   = 8'd0;
          state_d = StTail;
        end else if (cnt_q == LeadLast) begin
          cnt_d   = 8'd0;
          state_d = pulse_due ? StHigh : StTail;
        end
      end
      StHigh: begin
        // An aborted pulse is truncated and never counted.
        if (bus.abort) begin
          cnt_d   = 8'd0;
          state_d = StTail;
        end else if (cnt_q == PulseLast) begin
          cnt_d         = 8'd0;
          state_d       = StLow;
          rem_d         = (32'(rem_q) >= Q_PER_PULSE) ? rem_q - RemW'(Q_PER_PULSE) : '0;
          pulse_count_d = pulse_count_q + BUS_WIDTH'(1);
          q_sent_d      = (q_sum > QMax) ? BUS_WIDTH'(QMax) : BUS_WIDTH'(q_sum);
        end
      end
      StLow: begin
        if (bus.abort) begin
          cnt_d   = 8'd0;
          state_d = StTail;
        end else if (cnt_q == GapLast) begin
          cnt_d   = 8'd0;
          state_d = pulse_due ? StHigh : StTail;
        end
      end
      StTail: begin
        if (cnt_q == TailLast) begin
          cnt_d   = 8'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      rem_q         <= '0;
      pulse_count_q <= '0;
      q_sent_q      <= '0;
      start_q       <= 1'b0;
      ser_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      pulse_count_q <= pulse_count_d;
      q_sent_q      <= q_sent_d;
      start_q       <= (state_d == StStart);
      ser_q         <= (state_d == StHigh);
      busy_q        <= (state_d != StIdle);
      done_q        <= (state_d == StDone);
    end
  end

  assign bus.start_out    = start_q;
  assign bus.q_serialized = ser_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pulse_count  = pulse_count_q;
  assign bus.q_sent       = q_sent_q;

endmodule

// File: tb/tb_q_pulse_serializer.sv
// Randomized bench for q_pulse_serializer: every cycle of each frame is compared with a
// trace built from the frame-shape rules (segments, rounding, abort and reset effects).
module tb_q_pulse_serializer;

  localparam int BW    = 10;
  localparam int QPP   = 30;
  localparam int PD    = 3;
  localparam int GD    = 3;
  localparam int LC    = 2;
  localparam int TC    = 8;
  localparam int QPP_B = 600;
  localparam int QMAX  = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q_pulse_serializer_if #(.BUS_WIDTH(BW)) bus_a ();
  q_pulse_serializer_if #(.BUS_WIDTH(BW)) bus_b ();

  q_pulse_serializer #(
    .BUS_WIDTH(BW), .Q_PER_PULSE(QPP), .PULSE_DURATION(PD),
    .GAP_DURATION(GD), .LEAD_CYCLES(LC), .TAIL_CYCLES(TC)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  q_pulse_serializer #(
    .BUS_WIDTH(BW), .Q_PER_PULSE(QPP_B), .PULSE_DURATION(PD),
    .GAP_DURATION(GD), .LEAD_CYCLES(LC), .TAIL_CYCLES(TC)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  typedef enum int {KStart, KLead, KHigh, KLow, KTail, KDone} kind_e;

  int          n_checks = 0;
  int          n_errors = 0;
  kind_e       kinds[$];
  bit          lasth[$];
  logic [23:0] exp_q[$];
  logic [9:0]  last_pc = '0;
  logic [9:0]  last_qs = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] obs_a();
    return {bus_a.start_out, bus_a.q_serialized, bus_a.busy, bus_a.done,
            bus_a.pulse_count, bus_a.q_sent};
  endfunction

  task automatic push_kind(input kind_e k, input bit last);
    kinds.push_back(k);
    lasth.push_back(last);
  endtask

  // Expected outputs for cycles 1.. of a frame whose valid is sampled at cycle 0.
  task automatic build(input int q, input int abort_at, input int rst_at);
    int n, idx, cut, cnt, qs;
    kinds.delete();
    lasth.delete();
    exp_q.delete();
    n = (2 * q + QPP) / (2 * QPP);
    push_kind(KStart, 1'b0);
    for (int i = 0; i < LC; i++) push_kind(KLead, 1'b0);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < PD; c++) push_kind(KHigh, c == PD - 1);
      for (int c = 0; c < GD; c++) push_kind(KLow, 1'b0);
    end
    for (int i = 0; i < TC; i++) push_kind(KTail, 1'b0);
    push_kind(KDone, 1'b0);
    cut = -1;
    idx = abort_at - 1;
    if (abort_at >= 1 && idx < kinds.size() && kinds[idx] inside {KStart, KLead, KHigh, KLow}) begin
      while (kinds.size() > idx + 1) begin
        void'(kinds.pop_back());
        void'(lasth.pop_back());
      end
      cut = idx;
      for (int i = 0; i < TC; i++) push_kind(KTail, 1'b0);
      push_kind(KDone, 1'b0);
    end
    cnt = 0;
    foreach (kinds[i]) begin
      qs = cnt * QPP;
      if (qs > QMAX) qs = QMAX;
      exp_q.push_back({kinds[i] == KStart, kinds[i] == KHigh, 1'b1, kinds[i] == KDone,
                       10'(cnt), 10'(qs)});
      if (lasth[i] && i != cut) cnt++;
    end
    if (rst_at >= 1 && rst_at <= exp_q.size()) begin
      while (exp_q.size() > rst_at) void'(exp_q.pop_back());
      exp_q.push_back(24'd0);
    end
  endtask

  task automatic run_frame(input int q, input int abort_at, input int rst_at, input bit spam);
    int cyc;
    build(q, abort_at, rst_at);
    @(posedge clk); #1;
    bus_a.valid = 1'b1;
    bus_a.q_in  = 10'(q);
    bus_a.abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq($sformatf("idle_q%0d", q), 32'(obs_a()), 32'({4'b0000, last_pc, last_qs}));
    foreach (exp_q[i]) begin
      cyc = i + 1;
      @(posedge clk); #1;
      bus_a.valid = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_a.q_in  = 10'($urandom);
      bus_a.abort = (cyc == abort_at);
      rst         = (cyc == rst_at);
      if (rst_at >= 1 && cyc == rst_at + 1) begin
        bus_a.valid = 1'b0;
        bus_a.abort = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("q%0d_c%0d", q, cyc), 32'(obs_a()), 32'(exp_q[i]));
    end
    last_pc = exp_q[exp_q.size() - 1][19:10];
    last_qs = exp_q[exp_q.size() - 1][9:0];
  endtask

  initial begin
    int q, len0, ab, rs, nb, qsb;
    bit seen;
    bus_a.valid = 1'b0; bus_a.q_in = '0; bus_a.abort = 1'b0;
    bus_b.valid = 1'b0; bus_b.q_in = '0; bus_b.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_a", 32'(obs_a()), 32'd0);
    check_eq("reset_b", 32'({bus_b.start_out, bus_b.busy, bus_b.done, bus_b.pulse_count,
                             bus_b.q_sent}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(100, -1, -1, 1'b0);
    run_frame(105, -1, -1, 1'b0);
    run_frame(14, -1, -1, 1'b0);
    run_frame(300, 11, -1, 1'b0);
    run_frame(200, -1, -1, 1'b1);
    run_frame(100, -1, 8, 1'b0);
    run_frame(60, -1, -1, 1'b0);
    run_frame(0, -1, -1, 1'b1);
    run_frame(15, 2, -1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      q    = $urandom_range(0, QMAX);
      len0 = 2 + LC + ((2 * q + QPP) / (2 * QPP)) * (PD + GD) + TC;
      ab   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len0 + 2) : -1;
      rs   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len0) : -1;
      run_frame(q, ab, rs, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    bus_b.valid = 1'b1;
    bus_b.q_in  = 10'd1023;
    @(posedge clk); #1;
    bus_b.valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_b.done) seen = 1'b1;
    end
    nb  = (2 * 1023 + QPP_B) / (2 * QPP_B);
    qsb = (nb * QPP_B > QMAX) ? QMAX : nb * QPP_B;
    check_eq("b_done_seen", 32'(seen), 32'd1);
    check_eq("b_pulse_count", 32'(bus_b.pulse_count), 32'(nb));
    check_eq("b_q_sent", 32'(bus_b.q_sent), 32'(qsb));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
